// File: rtl/vga_arb_pkg.sv
// Shared types for the VGA framebuffer arbiter.
//   arb_state_t : arbiter FSM states
//   arb_owner_t : grant encoding driven on the `owner` port (0 none, 1 video, 2 CPU)
//   state_owner : maps an FSM state to the grant it represents
package vga_arb_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_VIDEO = 2'd1,
        ARB_CPU   = 2'd2,
        ARB_DRAIN = 2'd3
    } arb_state_t;

    typedef enum logic [1:0] {
        OWNER_NONE  = 2'd0,
        OWNER_VIDEO = 2'd1,
        OWNER_CPU   = 2'd2
    } arb_owner_t;

    // DRAIN holds no grant: nobody may issue strobes while the memory side empties.
    function automatic arb_owner_t state_owner(input arb_state_t s);
        case (s)
            ARB_VIDEO: state_owner = OWNER_VIDEO;
            ARB_CPU:   state_owner = OWNER_CPU;
            default:   state_owner = OWNER_NONE;
        endcase
    endfunction

endpackage

// File: rtl/wb_txn_counter.sv
// Outstanding-transaction counter for pipelined Wishbone bridges.
//   clk, rst_n  : clock, asynchronous active-low reset
//   inc         : a strobe was accepted this cycle
//   dec         : an ack was returned this cycle
//   count       : registered number of accepted-but-unacked strobes
//   count_next  : value count takes at the next edge
//   full        : count == MAX (caller must stop issuing)
//   empty       : count == 0
//   underflow   : ack seen with nothing outstanding
module wb_txn_counter #(
    parameter  int MAX = 8,
    localparam int CW  = $clog2(MAX) + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          inc,
    input  logic          dec,
    output logic [CW-1:0] count,
    output logic [CW-1:0] count_next,
    output logic          full,
    output logic          empty,
    output logic          underflow
);

    assign full      = (count == CW'(MAX));
    assign empty     = (count == '0);
    assign underflow = dec && empty;

    // A simultaneous accept and ack cancel; a stray ack at zero is absorbed.
    always_comb begin
        count_next = count;
        if (inc && !dec) begin
            count_next = count + CW'(1);
        end else if (dec && !inc && !empty) begin
            count_next = count - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else begin
            count <= count_next;
        end
    end

endmodule

// File: rtl/vga_fb_arbiter.sv
// Two-to-one pipelined Wishbone arbiter: VGA framebuffer fetch (vbus) and
// CPU (cbus) share one memory-side master port (mbus).
//   clk_i, rst_i        : clock, asynchronous active-low reset
//   vbus_* / cbus_*     : slave ports (cyc, stb, adr, we, sel, dat_m in;
//                         dat_s, ack, stall out)
//   mbus_*              : master port toward the memory controller
//   owner               : current grant (0 none, 1 video, 2 CPU)
//   err                 : sticky, set by an mbus ack with nothing outstanding
// Video wins ties; once the CPU has waited VIDEO_HOLD_LIMIT cycles the video
// grant is withdrawn. Ownership only changes with the memory side empty so
// every ack returns to the master that issued the strobe.
module vga_fb_arbiter
    import vga_arb_pkg::*;
#(
    parameter  int DATA_W           = 32,
    parameter  int ADDR_W           = 32,
    parameter  int MAX_OUTSTANDING  = 8,
    parameter  int VIDEO_HOLD_LIMIT = 256,
    localparam int SEL_W            = DATA_W / 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              vbus_cyc,
    input  logic              vbus_stb,
    input  logic [ADDR_W-1:0] vbus_adr,
    input  logic              vbus_we,
    input  logic [SEL_W-1:0]  vbus_sel,
    input  logic [DATA_W-1:0] vbus_dat_m,
    output logic [DATA_W-1:0] vbus_dat_s,
    output logic              vbus_ack,
    output logic              vbus_stall,
    input  logic              cbus_cyc,
    input  logic              cbus_stb,
    input  logic [ADDR_W-1:0] cbus_adr,
    input  logic              cbus_we,
    input  logic [SEL_W-1:0]  cbus_sel,
    input  logic [DATA_W-1:0] cbus_dat_m,
    output logic [DATA_W-1:0] cbus_dat_s,
    output logic              cbus_ack,
    output logic              cbus_stall,
    output logic              mbus_cyc,
    output logic              mbus_stb,
    output logic [ADDR_W-1:0] mbus_adr,
    output logic              mbus_we,
    output logic [SEL_W-1:0]  mbus_sel,
    output logic [DATA_W-1:0] mbus_dat_m,
    input  logic [DATA_W-1:0] mbus_dat_s,
    input  logic              mbus_ack,
    input  logic              mbus_stall,
    output logic [1:0]        owner,
    output logic              err
);

    localparam int HOLD_W = $clog2(VIDEO_HOLD_LIMIT + 1);
    localparam int CNT_W  = $clog2(MAX_OUTSTANDING) + 1;

    arb_state_t        state, state_next;
    arb_owner_t        prev_owner, prev_owner_next;
    logic [HOLD_W-1:0] hold, hold_next;
    logic              err_flag;

    logic [CNT_W-1:0]  count, count_next;
    logic              full, empty, underflow;
    logic              accept;

    logic              grant_video, grant_cpu, hold_hit, video_go;
    logic              route_video, route_cpu;

    wb_txn_counter #(
        .MAX (MAX_OUTSTANDING)
    ) u_txn_counter (
        .clk        (clk_i),
        .rst_n      (rst_i),
        .inc        (accept),
        .dec        (mbus_ack),
        .count      (count),
        .count_next (count_next),
        .full       (full),
        .empty      (empty),
        .underflow  (underflow)
    );

    assign grant_video = (state == ARB_VIDEO);
    assign grant_cpu   = (state == ARB_CPU);
    // Once the hold limit is hit, video is stalled in the same cycle the
    // handover to DRAIN is decided, so no further video strobe slips through.
    assign hold_hit    = grant_video && cbus_cyc && (hold == HOLD_W'(VIDEO_HOLD_LIMIT));
    assign video_go    = grant_video && !hold_hit;

    // Request path toward memory
    assign mbus_stb   = ((video_go && vbus_stb) || (grant_cpu && cbus_stb)) && !full;
    assign mbus_adr   = grant_cpu ? cbus_adr   : vbus_adr;
    assign mbus_we    = grant_cpu ? cbus_we    : vbus_we;
    assign mbus_sel   = grant_cpu ? cbus_sel   : vbus_sel;
    assign mbus_dat_m = grant_cpu ? cbus_dat_m : vbus_dat_m;
    // cyc stays up while anything is in flight, even after the owner drops it.
    assign mbus_cyc   = (grant_video && vbus_cyc) || (grant_cpu && cbus_cyc) || (count != '0);
    assign accept     = mbus_stb && !mbus_stall;

    assign vbus_stall = !video_go  || mbus_stall || full;
    assign cbus_stall = !grant_cpu || mbus_stall || full;

    // Return path: in DRAIN, acks belong to whoever issued the in-flight strobes.
    // Stray acks (nothing outstanding) are not forwarded to either master.
    assign route_video = grant_video || ((state == ARB_DRAIN) && (prev_owner == OWNER_VIDEO));
    assign route_cpu   = grant_cpu   || ((state == ARB_DRAIN) && (prev_owner == OWNER_CPU));
    assign vbus_ack    = mbus_ack && route_video && !empty;
    assign cbus_ack    = mbus_ack && route_cpu   && !empty;
    assign vbus_dat_s  = mbus_dat_s;
    assign cbus_dat_s  = mbus_dat_s;

    assign owner = state_owner(state);
    assign err   = err_flag;

    always_comb begin
        state_next      = state;
        prev_owner_next = prev_owner;
        hold_next       = hold;
        case (state)
            ARB_IDLE: begin
                if (vbus_cyc) begin
                    state_next = ARB_VIDEO;
                end else if (cbus_cyc) begin
                    state_next = ARB_CPU;
                end
            end
            ARB_VIDEO: begin
                // Post-update count lets a final ack coinciding with cyc drop skip DRAIN.
                if (!vbus_cyc) begin
                    if (count_next == '0) begin
                        state_next = cbus_cyc ? ARB_CPU : ARB_IDLE;
                    end else begin
                        state_next      = ARB_DRAIN;
                        prev_owner_next = OWNER_VIDEO;
                    end
                end else if (hold_hit) begin
                    state_next      = ARB_DRAIN;
                    prev_owner_next = OWNER_VIDEO;
                end else if (cbus_cyc) begin
                    hold_next = hold + HOLD_W'(1);
                end
            end
            ARB_CPU: begin
                if (!cbus_cyc) begin
                    if (count_next == '0) begin
                        state_next = vbus_cyc ? ARB_VIDEO : ARB_IDLE;
                    end else begin
                        state_next      = ARB_DRAIN;
                        prev_owner_next = OWNER_CPU;
                    end
                end
            end
            ARB_DRAIN: begin
                // The other master gets first claim so a forced handover can't bounce back.
                if (empty) begin
                    if (prev_owner == OWNER_VIDEO) begin
                        state_next = cbus_cyc ? ARB_CPU : (vbus_cyc ? ARB_VIDEO : ARB_IDLE);
                    end else begin
                        state_next = vbus_cyc ? ARB_VIDEO : (cbus_cyc ? ARB_CPU : ARB_IDLE);
                    end
                end
            end
            default: state_next = ARB_IDLE;
        endcase
        if (state_next != ARB_VIDEO) begin
            hold_next = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state      <= ARB_IDLE;
            prev_owner <= OWNER_NONE;
            hold       <= '0;
            err_flag   <= 1'b0;
        end else begin
            state      <= state_next;
            prev_owner <= prev_owner_next;
            hold       <= hold_next;
            err_flag   <= err_flag || underflow;
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
module tb_vga_fb_arbiter;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 32;
    localparam int SEL_W  = DATA_W / 8;

    logic              clk = 1'b0;
    logic              rst_i;
    logic              vbus_cyc, vbus_stb, vbus_we, vbus_ack, vbus_stall;
    logic [ADDR_W-1:0] vbus_adr;
    logic [SEL_W-1:0]  vbus_sel;
    logic [DATA_W-1:0] vbus_dat_m, vbus_dat_s;
    logic              cbus_cyc, cbus_stb, cbus_we, cbus_ack, cbus_stall;
    logic [ADDR_W-1:0] cbus_adr;
    logic [SEL_W-1:0]  cbus_sel;
    logic [DATA_W-1:0] cbus_dat_m, cbus_dat_s;
    logic              mbus_cyc, mbus_stb, mbus_we, mbus_ack, mbus_stall;
    logic [ADDR_W-1:0] mbus_adr;
    logic [SEL_W-1:0]  mbus_sel;
    logic [DATA_W-1:0] mbus_dat_m, mbus_dat_s;
    logic [1:0]        owner;
    logic              err;

    int checks   = 0;
    int failures = 0;

    // memory model: fixed 2-cycle ack latency when mem_auto is set
    bit   mem_auto;
    logic pipe0, pipe1;

    // per-cycle samples taken at the falling edge
    logic              s_vacc, s_cacc, s_macc, s_vack, s_cack, s_vstall, s_cstall;
    logic              s_mstb, s_mcyc, s_mwe, s_err;
    logic [1:0]        s_owner;
    logic [ADDR_W-1:0] s_madr;
    logic [DATA_W-1:0] s_mdat;

    always #5 clk = ~clk;

    vga_fb_arbiter #(
        .DATA_W           (DATA_W),
        .ADDR_W           (ADDR_W),
        .MAX_OUTSTANDING  (8),
        .VIDEO_HOLD_LIMIT (16)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst_i),
        .vbus_cyc   (vbus_cyc),
        .vbus_stb   (vbus_stb),
        .vbus_adr   (vbus_adr),
        .vbus_we    (vbus_we),
        .vbus_sel   (vbus_sel),
        .vbus_dat_m (vbus_dat_m),
        .vbus_dat_s (vbus_dat_s),
        .vbus_ack   (vbus_ack),
        .vbus_stall (vbus_stall),
        .cbus_cyc   (cbus_cyc),
        .cbus_stb   (cbus_stb),
        .cbus_adr   (cbus_adr),
        .cbus_we    (cbus_we),
        .cbus_sel   (cbus_sel),
        .cbus_dat_m (cbus_dat_m),
        .cbus_dat_s (cbus_dat_s),
        .cbus_ack   (cbus_ack),
        .cbus_stall (cbus_stall),
        .mbus_cyc   (mbus_cyc),
        .mbus_stb   (mbus_stb),
        .mbus_adr   (mbus_adr),
        .mbus_we    (mbus_we),
        .mbus_sel   (mbus_sel),
        .mbus_dat_m (mbus_dat_m),
        .mbus_dat_s (mbus_dat_s),
        .mbus_ack   (mbus_ack),
        .mbus_stall (mbus_stall),
        .owner      (owner),
        .err        (err)
    );

    // One bus cycle: inputs already driven after the previous rising edge.
    task automatic cyc();
        if (mem_auto) mbus_ack = pipe1;
        @(negedge clk);
        s_vacc   = vbus_stb & ~vbus_stall;
        s_cacc   = cbus_stb & ~cbus_stall;
        s_macc   = mbus_stb & ~mbus_stall;
        s_vack   = vbus_ack;
        s_cack   = cbus_ack;
        s_vstall = vbus_stall;
        s_cstall = cbus_stall;
        s_mstb   = mbus_stb;
        s_mcyc   = mbus_cyc;
        s_mwe    = mbus_we;
        s_madr   = mbus_adr;
        s_mdat   = mbus_dat_m;
        s_err    = err;
        s_owner  = owner;
        if (mem_auto) begin
            pipe1 = pipe0;
            pipe0 = s_macc;
        end else begin
            pipe1 = 1'b0;
            pipe0 = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_i    = 1'b0;
        vbus_cyc = 1'b1;
        mbus_ack = 1'b1;
        cyc();
        checks++;
        if (s_owner !== 2'd0) begin failures++; $display("FAIL reset_owner: got %0d want 0", s_owner); end
        checks++;
        if (s_err !== 1'b0 || s_mcyc !== 1'b0 || s_mstb !== 1'b0) begin
            failures++; $display("FAIL reset_mbus: err=%b cyc=%b stb=%b want 0 0 0", s_err, s_mcyc, s_mstb);
        end
        checks++;
        if (s_vack !== 1'b0 || s_cack !== 1'b0 || s_vstall !== 1'b1 || s_cstall !== 1'b1) begin
            failures++; $display("FAIL reset_slaves: vack=%b cack=%b vstall=%b cstall=%b want 0 0 1 1", s_vack, s_cack, s_vstall, s_cstall);
        end
        vbus_cyc = 1'b0;
        mbus_ack = 1'b0;
        rst_i    = 1'b1;
        cyc();
        checks++;
        if (s_owner !== 2'd0 || s_err !== 1'b0 || s_mcyc !== 1'b0) begin
            failures++; $display("FAIL reset_idle: owner=%0d err=%b cyc=%b want 0 0 0", s_owner, s_err, s_mcyc);
        end
    endtask

    task automatic test_video_only();
        int issued = 0, vacks = 0, owner_bad = 0, cstall_bad = 0, adr_bad = 0;
        bit done = 0;
        mem_auto = 1; pipe0 = 0; pipe1 = 0;
        mbus_dat_s = 32'hCAFE_0001;
        vbus_cyc = 1'b1; vbus_stb = 1'b1; vbus_we = 1'b0; vbus_adr = 32'h100;
        cyc();
        checks++;
        if (s_owner !== 2'd0 || s_vstall !== 1'b1 || s_mstb !== 1'b0) begin
            failures++; $display("FAIL video_grant_latency: owner=%0d vstall=%b mstb=%b want 0 1 0", s_owner, s_vstall, s_mstb);
        end
        for (int t = 0; t < 30 && !done; t++) begin
            vbus_stb = (issued < 4);
            vbus_adr = 32'h100 + 32'(issued * 4);
            cyc();
            if (s_owner !== 2'd1) owner_bad++;
            if (s_cstall !== 1'b1) cstall_bad++;
            if (s_macc && s_madr !== 32'h100 + 32'(issued * 4)) adr_bad++;
            if (s_vacc) issued++;
            if (s_vack) vacks++;
            if (vacks == 4) done = 1;
        end
        checks++;
        if (vacks !== 4 || issued !== 4) begin
            failures++; $display("FAIL video_acks: acks=%0d issued=%0d want 4 4", vacks, issued);
        end
        checks++;
        if (owner_bad !== 0 || cstall_bad !== 0 || adr_bad !== 0) begin
            failures++; $display("FAIL video_burst: owner_bad=%0d cstall_bad=%0d adr_bad=%0d want 0 0 0", owner_bad, cstall_bad, adr_bad);
        end
        checks++;
        if (vbus_dat_s !== 32'hCAFE_0001 || cbus_dat_s !== 32'hCAFE_0001) begin
            failures++; $display("FAIL dat_s_broadcast: v=%h c=%h want cafe0001", vbus_dat_s, cbus_dat_s);
        end
        vbus_cyc = 1'b0; vbus_stb = 1'b0;
        cyc();
        cyc();
        checks++;
        if (s_owner !== 2'd0 || s_mcyc !== 1'b0 || s_err !== 1'b0) begin
            failures++; $display("FAIL video_end_idle: owner=%0d mcyc=%b err=%b want 0 0 0", s_owner, s_mcyc, s_err);
        end
    endtask

    task automatic test_contention();
        int issued = 0, vacks = 0, cack_bad = 0, cpu_bad = 0;
        mem_auto = 0; mbus_ack = 1'b0;
        vbus_cyc = 1'b1; vbus_stb = 1'b1; vbus_adr = 32'h300;
        cbus_cyc = 1'b1; cbus_stb = 1'b1; cbus_we = 1'b1; cbus_adr = 32'h2000;
        cbus_sel = 4'hF; cbus_dat_m = 32'h1234_5678;
        cyc();
        checks++;
        if (s_owner !== 2'd0) begin failures++; $display("FAIL contention_first: owner=%0d want 0", s_owner); end
        for (int t = 0; t < 10 && issued < 3; t++) begin
            vbus_stb = 1'b1;
            cyc();
            if (s_owner !== 2'd1 || s_cstall !== 1'b1 || s_cacc) cpu_bad++;
            if (s_vacc) issued++;
        end
        checks++;
        if (issued !== 3 || cpu_bad !== 0) begin
            failures++; $display("FAIL contention_video_first: issued=%0d cpu_bad=%0d want 3 0", issued, cpu_bad);
        end
        vbus_stb = 1'b0; vbus_cyc = 1'b0;
        cyc();
        checks++;
        if (s_mcyc !== 1'b1 || s_mstb !== 1'b0) begin
            failures++; $display("FAIL contention_drop: mcyc=%b mstb=%b want 1 0", s_mcyc, s_mstb);
        end
        for (int i = 0; i < 3; i++) begin
            mbus_ack = 1'b1;
            cyc();
            if (s_vack) vacks++;
            if (s_cack || s_cstall !== 1'b1 || s_mstb) cack_bad++;
        end
        mbus_ack = 1'b0;
        checks++;
        if (vacks !== 3 || cack_bad !== 0) begin
            failures++; $display("FAIL drain_acks: vacks=%0d bad=%0d want 3 0", vacks, cack_bad);
        end
        cyc();
        checks++;
        if (s_owner === 2'd2 || s_cstall !== 1'b1 || s_mstb !== 1'b0) begin
            failures++; $display("FAIL handover_early: owner=%0d cstall=%b mstb=%b want !=2 1 0", s_owner, s_cstall, s_mstb);
        end
        cyc();
        checks++;
        if (s_owner !== 2'd2 || s_cacc !== 1'b1 || s_mwe !== 1'b1 || s_madr !== 32'h2000 || s_mdat !== 32'h1234_5678) begin
            failures++; $display("FAIL handover_cpu: owner=%0d acc=%b we=%b adr=%h dat=%h want 2 1 1 2000 12345678", s_owner, s_cacc, s_mwe, s_madr, s_mdat);
        end
        cbus_stb = 1'b0; mbus_ack = 1'b1;
        cyc();
        mbus_ack = 1'b0;
        checks++;
        if (s_cack !== 1'b1 || s_vack !== 1'b0) begin
            failures++; $display("FAIL cpu_ack_route: cack=%b vack=%b want 1 0", s_cack, s_vack);
        end
        cbus_cyc = 1'b0; cbus_we = 1'b0;
        cyc();
        cyc();
        checks++;
        if (s_owner !== 2'd0 || s_mcyc !== 1'b0) begin
            failures++; $display("FAIL contention_end: owner=%0d mcyc=%b want 0 0", s_owner, s_mcyc);
        end
    endtask

    task automatic test_hold_limit();
        int vacc_wait = 0, stall_at = 0, granted_at = 0, cstall_bad = 0;
        bit got_cack = 0, resumed = 0, cpu_acc = 0;
        mem_auto = 1; pipe0 = 0; pipe1 = 0;
        vbus_cyc = 1'b1; vbus_stb = 1'b1; vbus_adr = 32'h500;
        cyc(); cyc(); cyc(); cyc();
        cbus_cyc = 1'b1; cbus_stb = 1'b1; cbus_we = 1'b1; cbus_adr = 32'h4000;
        for (int w = 1; w <= 30 && granted_at == 0; w++) begin
            cyc();
            if (s_owner === 2'd2) begin
                granted_at = w;
                cpu_acc    = s_cacc;
            end else begin
                if (s_vacc) vacc_wait++;
                if (s_vstall && stall_at == 0) stall_at = w;
                if (s_cstall !== 1'b1) cstall_bad++;
            end
        end
        checks++;
        if (vacc_wait !== 16 || stall_at !== 17) begin
            failures++; $display("FAIL hold_limit_stall: video_accepts=%0d stall_cycle=%0d want 16 17", vacc_wait, stall_at);
        end
        checks++;
        if (granted_at !== 20 || cpu_acc !== 1'b1 || cstall_bad !== 0) begin
            failures++; $display("FAIL hold_limit_grant: grant_cycle=%0d cpu_acc=%b cstall_bad=%0d want 20 1 0", granted_at, cpu_acc, cstall_bad);
        end
        cbus_stb = 1'b0;
        for (int t = 0; t < 6 && !got_cack; t++) begin
            cyc();
            if (s_cack) got_cack = 1;
        end
        checks++;
        if (got_cack !== 1'b1) begin failures++; $display("FAIL hold_cpu_ack: got=%b want 1", got_cack); end
        cbus_cyc = 1'b0; cbus_we = 1'b0;
        cyc();
        for (int t = 0; t < 5 && !resumed; t++) begin
            cyc();
            if (s_owner === 2'd1 && s_vacc) resumed = 1;
        end
        checks++;
        if (resumed !== 1'b1) begin failures++; $display("FAIL hold_video_resume: resumed=%b want 1", resumed); end
        vbus_stb = 1'b0;
        cyc(); cyc(); cyc(); cyc();
        vbus_cyc = 1'b0;
        cyc(); cyc();
        checks++;
        if (s_owner !== 2'd0 || s_mcyc !== 1'b0 || s_err !== 1'b0) begin
            failures++; $display("FAIL hold_end: owner=%0d mcyc=%b err=%b want 0 0 0", s_owner, s_mcyc, s_err);
        end
    endtask

    task automatic test_outstanding_cap();
        int acc = 0, acc2 = 0, vacks = 0;
        mem_auto = 0; mbus_ack = 1'b0;
        vbus_cyc = 1'b1; vbus_stb = 1'b1; vbus_adr = 32'h700;
        cyc();
        for (int t = 0; t < 12; t++) begin
            cyc();
            if (s_macc) acc++;
        end
        checks++;
        if (acc !== 8 || s_vstall !== 1'b1 || s_mstb !== 1'b0) begin
            failures++; $display("FAIL cap_full: accepts=%0d vstall=%b mstb=%b want 8 1 0", acc, s_vstall, s_mstb);
        end
        mbus_ack = 1'b1;
        cyc();
        mbus_ack = 1'b0;
        checks++;
        if (s_vack !== 1'b1 || s_macc !== 1'b0) begin
            failures++; $display("FAIL cap_ack: vack=%b acc=%b want 1 0", s_vack, s_macc);
        end
        for (int t = 0; t < 4; t++) begin
            cyc();
            if (s_macc) acc2++;
        end
        checks++;
        if (acc2 !== 1) begin failures++; $display("FAIL cap_one_more: accepts=%0d want 1", acc2); end
        vbus_stb = 1'b0; mbus_ack = 1'b1;
        for (int t = 0; t < 8; t++) begin
            cyc();
            if (s_vack) vacks++;
        end
        mbus_ack = 1'b0; vbus_cyc = 1'b0;
        cyc(); cyc();
        checks++;
        if (vacks !== 8 || s_owner !== 2'd0 || s_mcyc !== 1'b0 || s_err !== 1'b0) begin
            failures++; $display("FAIL cap_drain: acks=%0d owner=%0d mcyc=%b err=%b want 8 0 0 0", vacks, s_owner, s_mcyc, s_err);
        end
    endtask

    task automatic test_spurious_ack();
        mem_auto = 0;
        mbus_ack = 1'b1;
        cyc();
        mbus_ack = 1'b0;
        checks++;
        if (s_vack !== 1'b0 || s_cack !== 1'b0) begin
            failures++; $display("FAIL spurious_route: vack=%b cack=%b want 0 0", s_vack, s_cack);
        end
        cyc();
        checks++;
        if (s_err !== 1'b1 || s_mcyc !== 1'b0 || s_owner !== 2'd0) begin
            failures++; $display("FAIL spurious_err: err=%b mcyc=%b owner=%0d want 1 0 0", s_err, s_mcyc, s_owner);
        end
    endtask

    task automatic test_reset_mid_burst();
        int acc = 0;
        mem_auto = 0; mbus_ack = 1'b0;
        vbus_cyc = 1'b1; vbus_stb = 1'b1; vbus_adr = 32'h900;
        for (int t = 0; t < 4; t++) begin
            cyc();
            if (s_macc) acc++;
        end
        checks++;
        if (acc !== 3 || s_err !== 1'b1) begin
            failures++; $display("FAIL midreset_setup: accepts=%0d err=%b want 3 1", acc, s_err);
        end
        rst_i    = 1'b0;
        mbus_ack = 1'b1;
        #1;
        checks++;
        if (owner !== 2'd0 || err !== 1'b0 || mbus_cyc !== 1'b0 || mbus_stb !== 1'b0) begin
            failures++; $display("FAIL midreset_mbus: owner=%0d err=%b cyc=%b stb=%b want 0 0 0 0", owner, err, mbus_cyc, mbus_stb);
        end
        checks++;
        if (vbus_stall !== 1'b1 || cbus_stall !== 1'b1 || vbus_ack !== 1'b0 || cbus_ack !== 1'b0) begin
            failures++; $display("FAIL midreset_slaves: vstall=%b cstall=%b vack=%b cack=%b want 1 1 0 0", vbus_stall, cbus_stall, vbus_ack, cbus_ack);
        end
        mbus_ack = 1'b0; vbus_cyc = 1'b0; vbus_stb = 1'b0;
        #2;
        rst_i = 1'b1;
        @(posedge clk);
        #1;
        mbus_ack = 1'b1;
        cyc();
        mbus_ack = 1'b0;
        checks++;
        if (s_vack !== 1'b0) begin failures++; $display("FAIL midreset_stray_ack: vack=%b want 0", s_vack); end
        cyc();
        checks++;
        if (s_err !== 1'b1 || s_mcyc !== 1'b0) begin
            failures++; $display("FAIL midreset_err: err=%b mcyc=%b want 1 0", s_err, s_mcyc);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i      = 1'b0;
        vbus_cyc   = 1'b0; vbus_stb = 1'b0; vbus_we = 1'b0;
        vbus_adr   = '0;   vbus_sel = 4'hF; vbus_dat_m = '0;
        cbus_cyc   = 1'b0; cbus_stb = 1'b0; cbus_we = 1'b0;
        cbus_adr   = '0;   cbus_sel = 4'hF; cbus_dat_m = '0;
        mbus_ack   = 1'b0; mbus_stall = 1'b0; mbus_dat_s = '0;
        mem_auto   = 0; pipe0 = 1'b0; pipe1 = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_video_only();
        test_contention();
        test_hold_limit();
        test_outstanding_cap();
        test_spurious_ack();
        test_reset_mid_burst();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_fb_arbiter.md
# vga_fb_arbiter

Two-to-one pipelined Wishbone arbiter between the VGA display controller's framebuffer master port (`outbus`) and the CPU's path into video RAM, driving a single master port toward the memory controller. Video gets priority, but a bounded hold limit guarantees CPU access during long scanline fetches. It tracks outstanding transactions so acks always return to the master that issued them, and ownership changes only once the memory side has drained.

## Interface
- `MAX_OUTSTANDING`, 8: maximum accepted-but-unacked strobes on `mbus`; power of two, ≥2.
- `VIDEO_HOLD_LIMIT`, 256: cycles video may keep the grant while the CPU is requesting before forced handover.
- `clk_i` in 1: single clock for all ports.
- `rst_i` in 1: reset, asynchronous, active-low.
- `vbus` if_wb.slave: video port (cyc, stb, adr, we, sel, dat_m in; dat_s, ack, stall out).
- `cbus` if_wb.slave: CPU port, same signal set.
- `mbus` if_wb.master: memory-side port.
- `owner` out 2: current grant; 0 none, 1 video, 2 CPU.
- `err` out 1: sticky; set on an `mbus.ack` received with zero outstanding.

## Operation
- States: `ARB_IDLE`, `ARB_VIDEO`, `ARB_CPU`, `ARB_DRAIN`.
- IDLE: `vbus.cyc` → VIDEO; else `cbus.cyc` → CPU; both → VIDEO.
- VIDEO: forward `vbus` stb/adr/we/sel/dat_m to `mbus`.
  - If `vbus.cyc` drops: → CPU when outstanding==0 and `cbus.cyc`; → IDLE when outstanding==0; otherwise → DRAIN.
  - If the hold counter reaches `VIDEO_HOLD_LIMIT` with `cbus.cyc` high → DRAIN; video is stalled (its cyc may stay high).
- CPU: forward `cbus`. The CPU is never preempted. When `cbus.cyc` drops, go to VIDEO, IDLE or DRAIN by the same rule with the two masters swapped.
- DRAIN: no strobes forwarded, and both slaves see stall=1. Acks route to the previous owner. When outstanding==0, grant passes to the other master if it is requesting; else to the previous owner if it is still requesting; else → IDLE.
- Outstanding counter:
  - +1 on `mbus.stb & ~mbus.stall`; −1 on `mbus.ack`; both together → unchanged.
  - At `MAX_OUTSTANDING`, the owner is stalled and `mbus.stb`=0.
  - An ack at 0 leaves the counter at 0 and sets `err`.
- Hold counter: increments each VIDEO cycle while `cbus.cyc`=1, saturates at the limit, and clears on entering any other state.
- `mbus.cyc` = owner's cyc OR (outstanding≠0).
- `dat_s` is broadcast to both slaves. `ack` goes only to the registered owner (previous owner in DRAIN); the non-owner sees ack=0.
- Non-owner sees stall=1. Owner sees stall = `mbus.stall` OR counter full.

## Timing
- Reset values: state IDLE, both counters 0, `owner`=0, `err`=0, `mbus.cyc`/`mbus.stb`=0, both slave ack=0, both slave stall=1.
- Grant is registered: the first strobe can be forwarded one cycle after `cyc` is first seen in IDLE.
- Request forwarding is combinational (0 cycles). The ack/`dat_s` return path is combinational (0 cycles).
- Handover latency: the DRAIN→new-owner transition occurs the cycle after the counter reaches 0. The new owner's first strobe is forwarded in the cycle after that transition.
- Simultaneous owner cyc drop and final ack: counter reaches 0 that cycle; next state is computed on the post-update count (no DRAIN visit).
- Asserting reset mid-transaction returns everything to reset values immediately; in-flight acks after reset are counted as `err`.

## Structure
- `vga_arb_pkg`: `arb_state_t` enum (4 states), `arb_owner_t` enum (NONE/VIDEO/CPU), `OWNER_*` constants.
- Sub-module `wb_txn_counter`: parameterised up/down outstanding counter with `full`, `empty` and `underflow` outputs; reusable by other bus bridges.

## Test plan
- Video only: `vbus` issues 4 reads, `mbus` acks with 2-cycle latency → 4 acks on `vbus`, `owner`=1 throughout, `cbus.stall`=1, ends IDLE with counter 0.
- Contention: both cyc rise together → VIDEO granted; after video drops cyc with 3 outstanding → DRAIN, 3 acks to `vbus`, then `owner`=2 and the CPU write completes.
- Hold limit with `VIDEO_HOLD_LIMIT`=16 and video streaming continuously with CPU waiting:
  - cycle 16 of CPU wait → video stalled, drain completes, CPU served.
  - After the CPU drops cyc, video regains grant and resumes.
- Outstanding cap with `MAX_OUTSTANDING`=8 and `mbus` withholding acks: after 8 accepts, `vbus.stall`=1 and `mbus.stb`=0; one ack → exactly one more strobe accepted.
- Spurious ack on `mbus` in IDLE → `err`=1, counter stays 0, no slave ack. Reset low mid-burst → all outputs at reset values within the same cycle.
